// File: rtl/hash_cmd_scheduler.sv
// Command front-end for the hash table engine: buffers requests, issues
// one op at a time, and queues completions in a first-word-fall-through FIFO.
module hash_cmd_scheduler #(
  parameter int KEY_WIDTH      = 32,
  parameter int VALUE_WIDTH    = 32,
  parameter int CHAINING_SIZE  = 4,
  parameter int CMD_DEPTH      = 8,
  parameter int RSP_DEPTH      = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [1:0]                       cmd_op,
  input  logic [KEY_WIDTH-1:0]             cmd_key,
  input  logic [VALUE_WIDTH-1:0]           cmd_value,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [1:0]                       rsp_op,
  output logic [VALUE_WIDTH-1:0]           rsp_value,
  output logic                             rsp_error,
  output logic                             rsp_timeout,
  output logic [$clog2(CHAINING_SIZE)-1:0] rsp_collision,
  output logic [KEY_WIDTH-1:0]             ht_key_in,
  output logic [VALUE_WIDTH-1:0]           ht_value_in,
  output logic [1:0]                       ht_op_sel,
  output logic                             ht_op_en,
  input  logic [VALUE_WIDTH-1:0]           ht_value_out,
  input  logic                             ht_op_done,
  input  logic                             ht_op_error,
  input  logic [$clog2(CHAINING_SIZE)-1:0] ht_collision_count,
  output logic                             busy,
  output logic [$clog2(CMD_DEPTH):0]       cmd_count
);

  localparam int CW = $clog2(CHAINING_SIZE);
  localparam int CA = $clog2(CMD_DEPTH);
  localparam int RA = $clog2(RSP_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, RESP, GAP
  } state_t;

  state_t state;

  logic [1:0]             cq_op  [CMD_DEPTH];
  logic [KEY_WIDTH-1:0]   cq_key [CMD_DEPTH];
  logic [VALUE_WIDTH-1:0] cq_val [CMD_DEPTH];
  logic [CA:0]            cw, cr;
  logic                   cpush, cpop, cempty, cfull;

  logic [1:0]             rq_op  [RSP_DEPTH];
  logic [VALUE_WIDTH-1:0] rq_val [RSP_DEPTH];
  logic                   rq_err [RSP_DEPTH];
  logic                   rq_to  [RSP_DEPTH];
  logic [CW-1:0]          rq_col [RSP_DEPTH];
  logic [RA:0]            rw, rr;
  logic                   rpush, rpop, rfull;

  logic [VALUE_WIDTH-1:0] res_val;
  logic                   res_err, res_to;
  logic [CW-1:0]          res_col;
  logic [TW-1:0]          tcnt;

  assign cempty    = (cw == cr);
  assign cfull     = (cw[CA] != cr[CA]) && (cw[CA-1:0] == cr[CA-1:0]);
  assign cmd_ready = !cfull;
  assign cmd_count = cw - cr;
  assign cpush     = cmd_valid && cmd_ready;
  assign cpop      = (state == IDLE) && !cempty;

  assign rfull     = (rw[RA] != rr[RA]) && (rw[RA-1:0] == rr[RA-1:0]);
  assign rsp_valid = (rw != rr);
  assign rpush     = (state == RESP) && !rfull;
  assign rpop      = rsp_valid && rsp_ready;
  assign busy      = (state != IDLE);

  // Head fields read as zero while empty so nothing stale leaks out
  assign rsp_op        = rsp_valid ? rq_op[rr[RA-1:0]]  : '0;
  assign rsp_value     = rsp_valid ? rq_val[rr[RA-1:0]] : '0;
  assign rsp_error     = rsp_valid ? rq_err[rr[RA-1:0]] : 1'b0;
  assign rsp_timeout   = rsp_valid ? rq_to[rr[RA-1:0]]  : 1'b0;
  assign rsp_collision = rsp_valid ? rq_col[rr[RA-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (cpush) begin
      cq_op[cw[CA-1:0]]  <= cmd_op;
      cq_key[cw[CA-1:0]] <= cmd_key;
      cq_val[cw[CA-1:0]] <= cmd_value;
    end
    if (rpush) begin
      rq_op[rw[RA-1:0]]  <= ht_op_sel;
      rq_val[rw[RA-1:0]] <= res_val;
      rq_err[rw[RA-1:0]] <= res_err;
      rq_to[rw[RA-1:0]]  <= res_to;
      rq_col[rw[RA-1:0]] <= res_col;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cw <= '0;
      cr <= '0;
      rw <= '0;
      rr <= '0;
    end else begin
      if (cpush) cw <= cw + 1'b1;
      if (cpop)  cr <= cr + 1'b1;
      if (rpush) rw <= rw + 1'b1;
      if (rpop)  rr <= rr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ht_key_in   <= '0;
      ht_value_in <= '0;
      ht_op_sel   <= '0;
      ht_op_en    <= 1'b0;
      res_val     <= '0;
      res_err     <= 1'b0;
      res_to      <= 1'b0;
      res_col     <= '0;
      tcnt        <= '0;
    end else begin
      ht_op_en <= 1'b0;
      unique case (state)
        IDLE: if (!cempty) begin
          ht_key_in   <= cq_key[cr[CA-1:0]];
          ht_value_in <= cq_val[cr[CA-1:0]];
          ht_op_sel   <= cq_op[cr[CA-1:0]];
          res_val     <= '0;
          res_to      <= 1'b0;
          res_col     <= '0;
          // Illegal opcode never reaches the engine
          if (cq_op[cr[CA-1:0]] == 2'b11) begin
            res_err <= 1'b1;
            state   <= RESP;
          end else begin
            res_err  <= 1'b0;
            ht_op_en <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          tcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (ht_op_done) begin
            res_err <= ht_op_error;
            res_col <= ht_collision_count;
            if (ht_op_sel == 2'b10) res_val <= ht_value_out;
            state <= RESP;
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            res_err <= 1'b1;
            res_to  <= 1'b1;
            state   <= RESP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RESP: if (!rfull) state <= GAP;
        GAP:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_cmd_scheduler.sv
// Directed bench for hash_cmd_scheduler with a small latency-programmable
// engine model; expected values are hand-computed per vector.
module tb_hash_cmd_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_key;
  logic [31:0] cmd_value;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_op;
  logic [31:0] rsp_value;
  logic        rsp_error;
  logic        rsp_timeout;
  logic [1:0]  rsp_collision;
  logic [31:0] ht_key_in;
  logic [31:0] ht_value_in;
  logic [1:0]  ht_op_sel;
  logic        ht_op_en;
  logic [31:0] ht_value_out;
  logic        ht_op_done;
  logic        ht_op_error;
  logic [1:0]  ht_collision_count;
  logic        busy;
  logic [3:0]  cmd_count;

  int checks = 0;
  int errors = 0;

  logic        eng_on;
  int          eng_lat;
  logic [31:0] eng_base;
  logic        eng_err;
  logic [1:0]  eng_coll;
  logic        epend;
  int          ecnt;
  logic [31:0] ekey;
  int          en_cnt;

  always #5 clk = ~clk;

  hash_cmd_scheduler dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_key(cmd_key), .cmd_value(cmd_value),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_op(rsp_op), .rsp_value(rsp_value),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .rsp_collision(rsp_collision),
    .ht_key_in(ht_key_in), .ht_value_in(ht_value_in),
    .ht_op_sel(ht_op_sel), .ht_op_en(ht_op_en),
    .ht_value_out(ht_value_out), .ht_op_done(ht_op_done),
    .ht_op_error(ht_op_error),
    .ht_collision_count(ht_collision_count),
    .busy(busy), .cmd_count(cmd_count)
  );

  assign ht_op_error        = eng_err;
  assign ht_collision_count = eng_coll;

  // Engine model: done arrives eng_lat cycles after the op_en cycle
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      epend        <= 1'b0;
      ecnt         <= 0;
      ekey         <= '0;
      ht_op_done   <= 1'b0;
      ht_value_out <= '0;
    end else begin
      ht_op_done <= 1'b0;
      if (ht_op_en && eng_on) begin
        epend <= 1'b1;
        ecnt  <= eng_lat;
        ekey  <= ht_key_in;
      end else if (epend) begin
        if (ecnt <= 1) begin
          epend        <= 1'b0;
          ht_op_done   <= 1'b1;
          ht_value_out <= ekey + eng_base;
        end else begin
          ecnt <= ecnt - 1;
        end
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) en_cnt <= 0;
    else if (ht_op_en) en_cnt <= en_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [31:0] key,
                      input logic [31:0] val);
    int n = 0;
    while (!cmd_ready && n < 500) begin
      tick();
      n++;
    end
    if (!cmd_ready) check("push_wait", 0, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_key   = key;
    cmd_value = val;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input logic [1:0] op,
                            input logic [31:0] val, input logic err,
                            input logic to, input logic [1:0] col);
    int n = 0;
    while (!rsp_valid && n < 500) begin
      tick();
      n++;
    end
    check({tag, ".valid"}, rsp_valid, 1);
    check({tag, ".op"}, rsp_op, op);
    check({tag, ".value"}, rsp_value, val);
    check({tag, ".error"}, rsp_error, err);
    check({tag, ".timeout"}, rsp_timeout, to);
    check({tag, ".coll"}, rsp_collision, col);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int snap;
    int n;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_key   = '0;
    cmd_value = '0;
    rsp_ready = 1'b0;
    eng_on    = 1'b0;
    eng_lat   = 1;
    eng_base  = '0;
    eng_err   = 1'b0;
    eng_coll  = '0;
    repeat (3) tick();
    check("rst.op_en", ht_op_en, 0);
    check("rst.key", ht_key_in, 0);
    check("rst.sel", ht_op_sel, 0);
    check("rst.busy", busy, 0);
    check("rst.count", cmd_count, 0);
    check("rst.rsp_valid", rsp_valid, 0);
    check("rst.rsp_op", rsp_op, 0);
    check("rst.cmd_ready", cmd_ready, 1);
    rst = 1'b0;
    tick();

    // Insert with silent engine: single op_en pulse, then forced timeout
    push(2'b00, 32'h05, 32'hAA);
    check("t1.en_n1", ht_op_en, 0);
    tick();
    check("t1.en_n2", ht_op_en, 1);
    check("t1.sel", ht_op_sel, 2'b00);
    check("t1.key", ht_key_in, 32'h05);
    check("t1.val", ht_value_in, 32'hAA);
    tick();
    check("t1.en_n3", ht_op_en, 0);
    check("t1.busy", busy, 1);
    check("t1.key_hold", ht_key_in, 32'h05);
    expect_rsp("t1", 2'b00, 32'h0, 1'b1, 1'b1, 2'd0);
    repeat (4) tick();

    // Search answered at WAIT cycle 3
    eng_on   = 1'b1;
    eng_lat  = 2;
    eng_base = 32'hA5;
    eng_coll = 2'd1;
    push(2'b10, 32'h05, 32'h0);
    expect_rsp("t2", 2'b10, 32'hAA, 1'b0, 1'b0, 2'd1);

    // Non-search ops report value 0; engine error is propagated
    eng_base = 32'h100;
    push(2'b00, 32'h07, 32'h77);
    expect_rsp("t2i", 2'b00, 32'h0, 1'b0, 1'b0, 2'd1);
    eng_err = 1'b1;
    push(2'b01, 32'h09, 32'h0);
    expect_rsp("t2d", 2'b01, 32'h0, 1'b1, 1'b0, 2'd1);
    eng_err = 1'b0;
    repeat (4) tick();

    // Fill the command FIFO behind a slow engine
    eng_lat  = 10;
    eng_base = 32'h200;
    for (int i = 0; i < 9; i++) push(2'b10, 32'h10 + i, 32'h0);
    check("t3.count", cmd_count, 8);
    check("t3.ready", cmd_ready, 0);
    for (int i = 0; i < 9; i++)
      expect_rsp("t3", 2'b10, 32'h210 + i, 1'b0, 1'b0, 2'd1);
    repeat (4) tick();
    check("t3.count_end", cmd_count, 0);

    // Response back-pressure: 9th op stalls in RESP
    eng_lat  = 1;
    eng_base = 32'h300;
    eng_coll = 2'd2;
    for (int i = 0; i < 9; i++) push(2'b10, 32'h20 + i, 32'h0);
    repeat (100) tick();
    check("t4.busy", busy, 1);
    check("t4.rsp_valid", rsp_valid, 1);
    check("t4.count", cmd_count, 0);
    for (int i = 0; i < 9; i++)
      expect_rsp("t4", 2'b10, 32'h320 + i, 1'b0, 1'b0, 2'd2);
    repeat (6) tick();
    check("t4.idle", busy, 0);
    check("t4.empty", rsp_valid, 0);

    // Illegal opcode bypasses the engine
    snap = en_cnt;
    push(2'b11, 32'h3, 32'h0);
    expect_rsp("t5", 2'b11, 32'h0, 1'b1, 1'b0, 2'd0);
    repeat (4) tick();
    check("t5.no_en", en_cnt, snap);

    // Reset while a delete is in WAIT
    eng_on = 1'b0;
    push(2'b01, 32'h44, 32'h0);
    n = 0;
    while (!ht_op_en && n < 20) begin
      tick();
      n++;
    end
    check("t6.issued", ht_op_en, 1);
    repeat (3) tick();
    push(2'b10, 32'h55, 32'h0);
    check("t6.pre_count", cmd_count, 1);
    rst = 1'b1;
    #1;
    check("t6.op_en", ht_op_en, 0);
    check("t6.rsp_valid", rsp_valid, 0);
    check("t6.count", cmd_count, 0);
    check("t6.busy", busy, 0);
    tick();
    rst = 1'b0;
    tick();
    eng_on   = 1'b1;
    eng_lat  = 2;
    eng_base = 32'h10;
    push(2'b10, 32'h30, 32'h0);
    tick();
    check("t6.en", ht_op_en, 1);
    check("t6.sel", ht_op_sel, 2'b10);
    expect_rsp("t6", 2'b10, 32'h40, 1'b0, 1'b0, 2'd2);
    repeat (4) tick();
    check("t6.drained", rsp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
